// File: rtl/fht_bank_wr.sv
// fht_bank_wr: write-back controller for the FHT engine.
// Realigns the registered butterfly results with the read beat that produced
// them (LAT cycles earlier), writes them to the four banks, counts beats per
// stage, flips the ping-pong page and flags stage / transform completion.
module fht_bank_wr #(
  parameter int D_BIT  = 17,
  parameter int A_BIT  = 8,
  parameter int LAT    = 4,
  parameter int ST_BIT = 4
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iSTART,
  input  logic                    iST_LAST,
  input  logic                    iRD_VALID,
  input  logic [A_BIT-1:0]        iRD_ADDR,
  input  logic signed [D_BIT-1:0] iY_0,
  input  logic signed [D_BIT-1:0] iY_1,
  input  logic signed [D_BIT-1:0] iY_2,
  input  logic signed [D_BIT-1:0] iY_3,
  output logic                    oWR_EN,
  output logic [A_BIT-1:0]        oWR_ADDR,
  output logic                    oWR_PAGE,
  output logic signed [D_BIT-1:0] oD_0,
  output logic signed [D_BIT-1:0] oD_1,
  output logic signed [D_BIT-1:0] oD_2,
  output logic signed [D_BIT-1:0] oD_3,
  output logic                    oBUSY,
  output logic [ST_BIT-1:0]       oSTAGE,
  output logic                    oSTAGE_DONE,
  output logic                    oFHT_DONE,
  output logic                    oERR
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [A_BIT:0]    CNT_ONE  = {{A_BIT{1'b0}}, 1'b1};
  localparam logic [A_BIT:0]    CNT_FULL = {1'b1, {A_BIT{1'b0}}};
  localparam logic [ST_BIT-1:0] ST_ONE   = {{(ST_BIT-1){1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic [LAT-1:0]            dl_vld_q, dl_vld_d;
  logic [LAT-1:0][A_BIT-1:0] dl_addr_q, dl_addr_d;
  logic [A_BIT:0]            cnt_q, cnt_d, cnt_inc;
  logic                      wr_en_q, wr_en_d;
  logic                      stage_done_q, stage_done_d;
  logic                      fht_done_q, fht_done_d;
  logic                      err_q, err_d;
  logic                      page_q, page_d;
  logic [ST_BIT-1:0]         stage_q, stage_d;
  logic [A_BIT-1:0]          addr_q, addr_d;
  logic [3:0][D_BIT-1:0]     dat_q, dat_d;

  logic                      tap_vld;
  logic [A_BIT-1:0]          tap_addr;
  logic                      busy, start_acc, beat;

  // Tap of the delay line lines up with the iY_x sample of the same beat.
  assign tap_vld  = dl_vld_q[LAT-1];
  assign tap_addr = dl_addr_q[LAT-1];

  // Delay line: shifts every cycle regardless of state.
  always_comb begin
    dl_vld_d     = dl_vld_q;
    dl_addr_d    = dl_addr_q;
    dl_vld_d[0]  = iRD_VALID;
    dl_addr_d[0] = iRD_ADDR;
    for (int i = 1; i < LAT; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
    end
  end

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: leave RUN the cycle after the final beat is registered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (iSTART)       state_d = RUN;
      RUN:  if (stage_done_q) state_d = IDLE;
    endcase
  end

  // FSM outputs: start is only taken in IDLE, beats are only written in RUN.
  always_comb begin
    busy      = (state_q == RUN);
    start_acc = (state_q == IDLE) && iSTART;
    beat      = busy && tap_vld;
  end

  // Write-beat datapath, beat counter, page/stage bookkeeping.
  always_comb begin
    cnt_inc      = cnt_q + CNT_ONE;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    dat_d        = dat_q;
    page_d       = page_q;
    stage_d      = stage_q;
    wr_en_d      = beat;
    stage_done_d = beat && (cnt_inc == CNT_FULL);
    fht_done_d   = stage_done_d && iST_LAST;
    err_d        = err_q | (tap_vld && !busy);
    if (start_acc)  cnt_d = '0;
    else if (beat)  cnt_d = cnt_inc;
    if (beat) begin
      addr_d = tap_addr;
      dat_d  = {iY_3, iY_2, iY_1, iY_0};
    end
    // Final stage of a transform rewinds page/stage for the next one.
    if (stage_done_q) begin
      if (fht_done_q) begin
        page_d  = 1'b0;
        stage_d = '0;
      end else begin
        page_d  = ~page_q;
        stage_d = stage_q + ST_ONE;
      end
    end
  end

  // Datapath registers; reset aborts any stage and drops in-flight beats.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      dl_vld_q     <= '0;
      dl_addr_q    <= '0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      stage_done_q <= 1'b0;
      fht_done_q   <= 1'b0;
      err_q        <= 1'b0;
      page_q       <= 1'b0;
      stage_q      <= '0;
      addr_q       <= '0;
      dat_q        <= '0;
    end else begin
      dl_vld_q     <= dl_vld_d;
      dl_addr_q    <= dl_addr_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      stage_done_q <= stage_done_d;
      fht_done_q   <= fht_done_d;
      err_q        <= err_d;
      page_q       <= page_d;
      stage_q      <= stage_d;
      addr_q       <= addr_d;
      dat_q        <= dat_d;
    end
  end

  assign oWR_EN      = wr_en_q;
  assign oWR_ADDR    = addr_q;
  assign oWR_PAGE    = page_q;
  assign oD_0        = dat_q[0];
  assign oD_1        = dat_q[1];
  assign oD_2        = dat_q[2];
  assign oD_3        = dat_q[3];
  assign oBUSY       = busy;
  assign oSTAGE      = stage_q;
  assign oSTAGE_DONE = stage_done_q;
  assign oFHT_DONE   = fht_done_q;
  assign oERR        = err_q;

endmodule

// File: doc/fht_bank_wr.md
Name: fht_bank_wr

Overview:
- Write-back controller for the FHT engine; it is the write-side counterpart of the double-butterfly block, which reads the four data banks.
- Takes the four registered butterfly results and realigns them with the read address/valid that produced them, which entered the pipeline LAT cycles earlier.
- Drives write enable, address and data to the four banks, counts writes per stage, toggles the ping-pong page and signals stage/transform completion.

Parameters:
- D_BIT, 17, data word width (matches butterfly output)
- A_BIT, 8, bank address width; one stage = 2^A_BIT write beats
- LAT, 4, cycles from iRD_VALID/iRD_ADDR to valid iY_x at this block's input (>=1)
- ST_BIT, 4, stage counter width

Ports:
- iCLK  in  1  clock
- iRESET  in  1  reset
- iSTART  in  1  one-cycle pulse, begins a stage
- iST_LAST  in  1  current stage is the final stage (held for the stage)
- iRD_VALID  in  1  read beat issued to banks this cycle
- iRD_ADDR  in  A_BIT  bank address of that read beat
- iY_0..iY_3  in  D_BIT each, signed  butterfly results for banks 0..3
- oWR_EN  out  1  write strobe, all four banks
- oWR_ADDR  out  A_BIT  write address, common to the four banks
- oWR_PAGE  out  1  ping-pong page being written
- oD_0..oD_3  out  D_BIT each, signed  write data, banks 0..3
- oBUSY  out  1  stage in progress
- oSTAGE  out  ST_BIT  index of completed stages
- oSTAGE_DONE  out  1  pulse: last beat of stage written
- oFHT_DONE  out  1  pulse: last beat of final stage written
- oERR  out  1  sticky: valid beat arrived outside a stage

Behaviour:
- Reset (iRESET asynchronous, active-low; clock iCLK): all outputs 0; delay line cleared; write counter 0; state IDLE.
- FSM with two states: IDLE, RUN.
  - IDLE + iSTART -> RUN; oBUSY=1 from the next cycle.
  - RUN + final beat written -> IDLE.
  - iSTART in RUN is ignored.
- Delay line: LAT-deep shift register of {valid, addr}, fed by iRD_VALID/iRD_ADDR every cycle regardless of state.
- Write beat:
  - Condition: the tap output has valid=1 and state is RUN (the tap is evaluated at the cycle iY_x is sampled).
  - That cycle: iY_x is registered into oD_x and the tap addr into oWR_ADDR.
  - Next cycle: oWR_EN=1 for exactly that cycle.
  - Total latency: iRD_VALID at cycle t -> oWR_EN at t+LAT+1.
- Data: oD_x and oWR_ADDR hold their last values when oWR_EN=0. There is no arithmetic and no width change; data passes through bit-exact.
- Write counter:
  - A_BIT+1 wide, cleared on iSTART accepted.
  - Increments per write beat.
  - The beat for which the counter reaches 2^A_BIT is the final beat.
- Final beat:
  - oSTAGE_DONE=1 in the same cycle as its oWR_EN.
  - oFHT_DONE=1 in the same cycle if iST_LAST=1.
  - Next cycle: oWR_PAGE toggles, oSTAGE increments (wraps modulo 2^ST_BIT), oBUSY=0.
  - If iST_LAST=1, oSTAGE and oWR_PAGE are instead cleared to 0 for the next transform.
- Tap valid=1 while IDLE: no write, the beat is dropped, oERR set. oERR is cleared only by reset.
- Simultaneous final beat and iSTART: iSTART is ignored (the state is still RUN that cycle).
- A new iSTART is accepted from the cycle oBUSY falls.
- Gaps in iRD_VALID are allowed; beats are written in arrival order and the address is not reordered.
- Reset mid-stage: abort immediately, no further oWR_EN, counter/page/stage return to 0.

Test Plan:
- Basic stage, LAT=4, A_BIT=3:
  - Stimulus: iSTART, then 8 consecutive iRD_VALID with addr 0..7, iY_0=addr+100 aligned 4 cycles later.
  - Required: oWR_EN at cycles 6..13 (iSTART at 0, first valid at 1); oWR_ADDR 0..7; oD_0 100..107.
  - Required: oSTAGE_DONE at cycle 13; oWR_PAGE=1 and oSTAGE=1 at cycle 14.
- Gapped reads:
  - Stimulus: valid pattern 1,0,1,1,0,0,1... for 8 beats.
  - Required: oWR_EN follows the same pattern delayed LAT+1; the done pulse is on the 8th beat only.
- Final stage:
  - Stimulus: three stages, iST_LAST=1 on the third.
  - Required: oFHT_DONE pulses once together with the 3rd oSTAGE_DONE; oSTAGE=0 and oWR_PAGE=0 afterwards.
- Stray valid:
  - Stimulus: iRD_VALID while IDLE.
  - Required: no oWR_EN, oERR=1 and stays 1 through a subsequent normal stage.
- iSTART during RUN and on the final-beat cycle:
  - Required: ignored, counter not cleared.
  - Required: a restart is accepted one cycle after oBUSY falls.
- Reset asserted after the 3rd write beat:
  - Required: all outputs 0 asynchronously; no oWR_EN afterwards even though the delay line held valid beats.
  - Required: a new stage after release writes from count 0.
